track_sequencer: RTL
====================

Name: track_sequencer

Overview:
Top-level sequencer for the acoustic tracking chain: Buffer pair → TDOA → angle LUT ROM → UARTInterface.
- Issues `restart` pulses to the buffers and TDOA.
- Waits for the capture and correlation to complete.
- Clamps `k_hat` into a LUT index and waits out the ROM read latency.
- Sends one angle byte per event to the UART, honouring `tx_busy`, then holds off before re-arming.
- Replaces the free-running, button-driven `restart`/`data_rdy` glue in ChipInterface.

Parameters:
- LUT_LATENCY, 2, ROM read latency in clocks, valid range 1..7.
- HOLDOFF_CYCLES, 50_000_000, dead time after each transmit (0.5 s at 100 MHz), minimum 1.
- TIMEOUT_CYCLES, 10_000_000, maximum clocks spent in CALC before abort, minimum 1.
- K_LIMIT, 42, maximum |k_hat| mapped into the LUT; LUT depth is 2*K_LIMIT+1.

Ports:
- clock  in  1  system clock (100 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; high = run tracking loop.
- start_calc  in  1  level from reference buffer: capture window full.
- tdoa_done  in  1  pulse/level from TDOA: k_hat valid.
- k_hat  in  8  signed two's-complement lag estimate.
- angle  in  8  LUT ROM output.
- tx_busy  in  1  UART busy flag.
- restart  out  1  one-cycle pulse to buffers and TDOA.
- lut_idx  out  8  registered ROM address.
- tx_valid  out  1  one-cycle pulse to UART data_rdy.
- tx_data  out  8  registered angle byte.
- state  out  3  current state encoding, for debug LEDs.
- capture_count  out  16  completed transmits (see Optional Feature).
- timeout_count  out  8  CALC aborts (see Optional Feature).

Behaviour:
- Reset (asynchronous, reset_n low): all outputs 0, state IDLE, all counters 0.
- State encodings:
  - IDLE=0, RESTART=1, ARMED=2, CALC=3, LUT_WAIT=4, SEND=5, HOLDOFF=6.
- IDLE:
  - enable high → RESTART.
- RESTART:
  - restart=1 for exactly this cycle → ARMED.
- ARMED:
  - enable low → IDLE.
  - start_calc high → CALC; the timeout counter loads 0.
- CALC:
  - tdoa_done high: register k_hat and lut_idx → LUT_WAIT.
  - The timeout counter reaching TIMEOUT_CYCLES-1 without tdoa_done → RESTART; timeout_count increments.
  - tdoa_done takes priority over timeout in the same cycle.
  - enable is ignored in this state.
- Clamp, with k_hat treated as signed:
  - k_hat < -K_LIMIT → lut_idx=0.
  - k_hat > K_LIMIT → lut_idx=2*K_LIMIT.
  - otherwise lut_idx = k_hat + K_LIMIT.
  - k_hat=-128 clamps to 0; there is no unsigned-negate trick.
- LUT_WAIT:
  - Count LUT_LATENCY clocks after lut_idx is registered, then latch angle into tx_data → SEND.
- SEND:
  - While tx_busy high, stay, with tx_valid=0.
  - On the first cycle tx_busy is low: tx_valid=1 for one cycle → HOLDOFF.
  - tx_data is stable from entry to SEND until the next LUT_WAIT exit.
- HOLDOFF:
  - Count HOLDOFF_CYCLES clocks.
  - At expiry, enable high → RESTART; enable low → IDLE.
- General rules:
  - restart and tx_valid are never asserted in the same cycle.
  - At most one tx_valid per restart.
  - Deasserting enable mid-calc or mid-send completes the current byte and then goes to IDLE via HOLDOFF.
  - lut_idx holds its last value outside CALC.

Optional Feature:
- Macro: SEQ_STATS_EN.
- Defined:
  - capture_count increments on each tx_valid.
  - timeout_count increments on each CALC timeout.
  - Both saturate: 16'hFFFF and 8'hFF.
  - Both are cleared only by reset_n.
- Undefined:
  - No counter flops are built.
  - capture_count and timeout_count are driven constant 0.
  - The timeout abort itself still operates.

Test Plan:
- Basic loop (HOLDOFF_CYCLES=100, TIMEOUT_CYCLES=1000, LUT_LATENCY=2):
  - Stimulus: reset_n low then high; enable=1; start_calc rises at t; tdoa_done at t+50 with k_hat=8'd5; ROM model returns angle=idx+1.
  - Required: one restart pulse two cycles after enable; lut_idx=47; tx_valid one pulse with tx_data=48; next restart 100 clocks after tx_valid.
- Clamp:
  - Stimulus: k_hat ∈ {-128, -43, -42, 0, 42, 43, 127}.
  - Required: lut_idx ∈ {0, 0, 0, 42, 84, 84, 84}.
- UART backpressure:
  - Stimulus: tx_busy held high 30 cycles on SEND entry.
  - Required: tx_valid=0 throughout; tx_valid fires on the first cycle tx_busy=0; tx_data unchanged.
- Timeout:
  - Stimulus: start_calc high, tdoa_done never asserts (TIMEOUT_CYCLES=1000).
  - Required: restart pulse exactly 1000 cycles after CALC entry; no tx_valid; timeout_count=1 when SEQ_STATS_EN is defined, 0 otherwise.
- Simultaneous events and disable:
  - Stimulus: tdoa_done coincides with the final timeout cycle.
  - Required: normal send, timeout_count unchanged.
  - Stimulus: enable dropped during CALC.
  - Required: byte still sent, then IDLE after holdoff, no further restart.
- Async reset mid-operation:
  - Stimulus: reset_n pulsed low mid-LUT_WAIT, between clock edges.
  - Required: outputs 0 and state=0 immediately, before the next clock edge; counters 0.

Source files
------------

// File: rtl/track_sequencer.sv
// Tracking-loop sequencer: restart -> capture -> TDOA -> clamped LUT lookup -> one UART byte -> holdoff.
// Optional saturating statistics counters are built when SEQ_STATS_EN is defined.
`timescale 1ns/1ps

module track_sequencer #(
    parameter int LUT_LATENCY    = 2,
    parameter int HOLDOFF_CYCLES = 50_000_000,
    parameter int TIMEOUT_CYCLES = 10_000_000,
    parameter int K_LIMIT        = 42
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        start_calc,
    input  logic        tdoa_done,
    input  logic [7:0]  k_hat,
    input  logic [7:0]  angle,
    input  logic        tx_busy,
    output logic        restart,
    output logic [7:0]  lut_idx,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic [2:0]  state,
    output logic [15:0] capture_count,
    output logic [7:0]  timeout_count
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RESTART  = 3'd1,
        ST_ARMED    = 3'd2,
        ST_CALC     = 3'd3,
        ST_LUT_WAIT = 3'd4,
        ST_SEND     = 3'd5,
        ST_HOLDOFF  = 3'd6
    } state_t;

    // One shared phase counter serves the CALC timeout, the ROM wait and the holdoff.
    localparam int CNT_MAX = (HOLDOFF_CYCLES > TIMEOUT_CYCLES)
                           ? ((HOLDOFF_CYCLES > LUT_LATENCY) ? HOLDOFF_CYCLES : LUT_LATENCY)
                           : ((TIMEOUT_CYCLES > LUT_LATENCY) ? TIMEOUT_CYCLES : LUT_LATENCY);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LW_LAST = CNT_W'(LUT_LATENCY);
    localparam logic [CNT_W-1:0] HO_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    localparam logic signed [8:0] K_POS   = 9'(K_LIMIT);
    localparam logic signed [8:0] K_NEG   = 9'(-K_LIMIT);
    localparam logic [7:0]        IDX_MAX = 8'(2 * K_LIMIT);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       lut_idx_reg, lut_idx_next;
    logic [7:0]       tx_data_reg, tx_data_next;

    logic signed [8:0] k_ext;
    logic [7:0]        clamped_idx;
    logic              timeout_hit;
    logic              tx_fire;

    // Sign-extend so -128 compares as a true negative rather than wrapping.
    assign k_ext = {k_hat[7], k_hat};

    always_comb begin
        clamped_idx = 8'(k_ext - K_NEG);
        if (k_ext < K_NEG) begin
            clamped_idx = 8'd0;
        end else if (k_ext > K_POS) begin
            clamped_idx = IDX_MAX;
        end
    end

    // tdoa_done wins over the timeout when both land on the same cycle.
    assign timeout_hit = (state_reg == ST_CALC) && !tdoa_done && (cnt_reg == TO_LAST);
    assign tx_fire     = (state_reg == ST_SEND) && !tx_busy;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            lut_idx_reg <= 8'd0;
            tx_data_reg <= 8'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            lut_idx_reg <= lut_idx_next;
            tx_data_reg <= tx_data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + CNT_W'(1);
        lut_idx_next = lut_idx_reg;
        tx_data_next = tx_data_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (enable) begin
                    state_next = ST_RESTART;
                end
            end
            ST_RESTART: begin
                cnt_next   = '0;
                state_next = ST_ARMED;
            end
            ST_ARMED: begin
                cnt_next = '0;
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (start_calc) begin
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (tdoa_done) begin
                    lut_idx_next = clamped_idx;
                    cnt_next     = '0;
                    state_next   = ST_LUT_WAIT;
                end else if (timeout_hit) begin
                    cnt_next   = '0;
                    state_next = ST_RESTART;
                end
            end
            ST_LUT_WAIT: begin
                // Address registered on entry; ROM data is settled LUT_LATENCY clocks later.
                if (cnt_reg == LW_LAST) begin
                    tx_data_next = angle;
                    cnt_next     = '0;
                    state_next   = ST_SEND;
                end
            end
            ST_SEND: begin
                cnt_next = '0;
                if (!tx_busy) begin
                    state_next = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_reg == HO_LAST) begin
                    cnt_next   = '0;
                    state_next = enable ? ST_RESTART : ST_IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign restart  = (state_reg == ST_RESTART);
    assign tx_valid = tx_fire;
    assign lut_idx  = lut_idx_reg;
    assign tx_data  = tx_data_reg;
    assign state    = state_reg;

`ifdef SEQ_STATS_EN
    logic [15:0] capture_count_reg;
    logic [7:0]  timeout_count_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            capture_count_reg <= 16'd0;
            timeout_count_reg <= 8'd0;
        end else begin
            if (tx_fire && (capture_count_reg != 16'hFFFF)) begin
                capture_count_reg <= capture_count_reg + 16'd1;
            end
            if (timeout_hit && (timeout_count_reg != 8'hFF)) begin
                timeout_count_reg <= timeout_count_reg + 8'd1;
            end
        end
    end

    assign capture_count = capture_count_reg;
    assign timeout_count = timeout_count_reg;
`else
    assign capture_count = 16'd0;
    assign timeout_count = 8'd0;
`endif

endmodule
